// File: rtl/sobel_if.sv
// Window-in / pixel-out bundle between the line buffers, the Sobel stage and the edge-map writer.
interface sobel_if;
  logic       start;
  logic [7:0] top_a, top_b, top_c;
  logic [7:0] mid_a, mid_b, mid_c;
  logic [7:0] bot_a, bot_b, bot_c;
  logic       rd_en;
  logic       busy;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic [9:0] col_idx;
  logic       row_done;

  modport master (
    output start, top_a, top_b, top_c, mid_a, mid_b, mid_c, bot_a, bot_b, bot_c,
    input  rd_en, busy, pix_out, pix_valid, col_idx, row_done
  );

  modport slave (
    input  start, top_a, top_b, top_c, mid_a, mid_b, mid_c, bot_a, bot_b, bot_c,
    output rd_en, busy, pix_out, pix_valid, col_idx, row_done
  );
endinterface

// File: rtl/sobel_window.sv
// Row sequencer and 3-stage Sobel |Gx|+|Gy| pipeline fed by three line buffers.
// One window per rd_en cycle in, one tagged pixel per cycle out, three cycles later.
module sobel_window #(
  parameter int WIDTH  = 640,
  parameter int THRESH = 0
) (
  input  logic     clk,
  input  logic     rst,
  sobel_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);

  state_t      state_r;
  logic [9:0]  col_r;
  logic        rd_en_r;
  logic        busy_r;

  logic        s1_valid_r;
  logic [9:0]  s1_col_r;
  logic [7:0]  s1_ta_r, s1_tb_r, s1_tc_r;
  logic [7:0]  s1_ma_r, s1_mc_r;
  logic [7:0]  s1_ba_r, s1_bb_r, s1_bc_r;

  logic        s2_valid_r;
  logic [9:0]  s2_col_r;
  logic        s2_last_r;
  logic signed [10:0] s2_gx_r, s2_gy_r;

  logic        s3_valid_r;
  logic [9:0]  s3_col_r;
  logic        s3_done_r;
  logic [7:0]  s3_pix_r;

  logic signed [10:0] gx_s, gy_s;
  logic [10:0] mag_s;
  logic [7:0]  sat_s;
  logic [7:0]  res_s;

  // 1-2-1 weighted sum of three pixels, 0..1020
  function automatic logic [10:0] wsum(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
    return {3'b000, p} + {2'b00, q, 1'b0} + {3'b000, r};
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic [10:0] res;
    if (v < 11'sd0) begin
      res = 11'(-v);
    end else begin
      res = 11'(v);
    end
    return res;
  endfunction

  // Row sequencer: IDLE -> RUN for WIDTH read cycles -> DRAIN until the pipeline empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      col_r   <= 10'd0;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= RUN;
            col_r   <= 10'd0;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (col_r == LAST_COL) begin
            state_r <= DRAIN;
            rd_en_r <= 1'b0;
          end else begin
            col_r <= col_r + 10'd1;
          end
        end
        DRAIN: begin
          // stage 3 holds the last pixel once stages 1 and 2 are empty
          if (!s1_valid_r && !s2_valid_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            col_r   <= 10'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          col_r   <= 10'd0;
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the 3x3 window presented while rd_en is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_col_r   <= 10'd0;
      s1_ta_r <= 8'd0; s1_tb_r <= 8'd0; s1_tc_r <= 8'd0;
      s1_ma_r <= 8'd0; s1_mc_r <= 8'd0;
      s1_ba_r <= 8'd0; s1_bb_r <= 8'd0; s1_bc_r <= 8'd0;
    end else begin
      s1_valid_r <= rd_en_r;
      if (rd_en_r) begin
        s1_col_r <= col_r;
        s1_ta_r  <= bus.top_a; s1_tb_r <= bus.top_b; s1_tc_r <= bus.top_c;
        s1_ma_r  <= bus.mid_a; s1_mc_r <= bus.mid_c;
        s1_ba_r  <= bus.bot_a; s1_bb_r <= bus.bot_b; s1_bc_r <= bus.bot_c;
      end
    end
  end

  // Gradients; both fit in signed 11 bits so the wrapping subtraction is exact
  always_comb begin
    gx_s = $signed(wsum(s1_tc_r, s1_mc_r, s1_bc_r) - wsum(s1_ta_r, s1_ma_r, s1_ba_r));
    gy_s = $signed(wsum(s1_ba_r, s1_bb_r, s1_bc_r) - wsum(s1_ta_r, s1_tb_r, s1_tc_r));
  end

  // Stage 2: register gradients and tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_col_r   <= 10'd0;
      s2_last_r  <= 1'b0;
      s2_gx_r    <= 11'sd0;
      s2_gy_r    <= 11'sd0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_col_r   <= s1_col_r;
      s2_last_r  <= (s1_col_r == LAST_COL);
      s2_gx_r    <= gx_s;
      s2_gy_r    <= gy_s;
    end
  end

  // Magnitude, saturation and optional binarisation of the saturated value
  always_comb begin
    mag_s = abs11(s2_gx_r) + abs11(s2_gy_r);
    if (mag_s > 11'd255) begin
      sat_s = 8'd255;
    end else begin
      sat_s = mag_s[7:0];
    end
    if (THRESH == 0) begin
      res_s = sat_s;
    end else if ($signed({24'd0, sat_s}) >= THRESH) begin
      res_s = 8'd255;
    end else begin
      res_s = 8'd0;
    end
  end

  // Stage 3: output register, payload forced to zero when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_r <= 1'b0;
      s3_col_r   <= 10'd0;
      s3_done_r  <= 1'b0;
      s3_pix_r   <= 8'd0;
    end else if (s2_valid_r) begin
      s3_valid_r <= 1'b1;
      s3_col_r   <= s2_col_r;
      s3_done_r  <= s2_last_r;
      s3_pix_r   <= res_s;
    end else begin
      s3_valid_r <= 1'b0;
      s3_col_r   <= 10'd0;
      s3_done_r  <= 1'b0;
      s3_pix_r   <= 8'd0;
    end
  end

  assign bus.rd_en     = rd_en_r;
  assign bus.busy      = busy_r;
  assign bus.pix_out   = s3_pix_r;
  assign bus.pix_valid = s3_valid_r;
  assign bus.col_idx   = s3_col_r;
  assign bus.row_done  = s3_done_r;

endmodule
